r_rr_arbiter: RTL and testbench

Round-robin arbiter that merges the R channels of NUM_SLAVES r_fifo instances onto one master-side AXI R channel. It sits in the crossbar's read-return path, after the per-slave clock-crossing FIFOs (rx side). It drives each FIFO's pop. Bursts are never interleaved: a grant is held from the first beat until the beat with RLAST is accepted.

---
 rtl/r_rr_arbiter_if.sv | 31 +++
 rtl/r_rr_arbiter.sv | 111 +++++++++++
 tb/tb_r_rr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/r_rr_arbiter_if.sv
// Merged R-channel bundle between the per-slave r_fifo fronts, the arbiter and the master.
// The arbiter binds to "master" because it sources the merged R channel.
interface r_rr_arbiter_if #(
   parameter int NUM_SLAVES = 4,
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_SLAVES-1:0]            fifo_empty;
   logic [NUM_SLAVES*ID_WIDTH-1:0]   fifo_RID;
   logic [NUM_SLAVES*DATA_WIDTH-1:0] fifo_RDATA;
   logic [NUM_SLAVES*2-1:0]          fifo_RRESP;
   logic [NUM_SLAVES-1:0]            fifo_RLAST;
   logic [NUM_SLAVES-1:0]            fifo_pop;
   logic                             RVALID;
   logic                             RREADY;
   logic [ID_WIDTH-1:0]              RID;
   logic [DATA_WIDTH-1:0]            RDATA;
   logic [1:0]                       RRESP;
   logic                             RLAST;
   logic                             busy;

   modport master (
      input  fifo_empty, fifo_RID, fifo_RDATA, fifo_RRESP, fifo_RLAST, RREADY,
      output fifo_pop, RVALID, RID, RDATA, RRESP, RLAST, busy
   );

   modport slave (
      output fifo_empty, fifo_RID, fifo_RDATA, fifo_RRESP, fifo_RLAST, RREADY,
      input  fifo_pop, RVALID, RID, RDATA, RRESP, RLAST, busy
   );
endinterface

// File: rtl/r_rr_arbiter.sv
// Round-robin merge of NUM_SLAVES r_fifo R channels onto one AXI R channel.
// A grant is held from the first beat until the RLAST beat is accepted.
module r_rr_arbiter #(
   parameter int NUM_SLAVES = 4,
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 32
) (
   input logic            clk,
   input logic            rst,
   r_rr_arbiter_if.master bus
);
   localparam int GW = $clog2(NUM_SLAVES);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;

   logic [0:0]    r_state;
   logic [GW-1:0] r_grant;
   logic [GW-1:0] r_last_grant;

   logic                  w_found;
   logic [GW-1:0]         w_next;
   logic                  w_in_burst;
   logic                  w_rvalid;
   logic                  w_accept;
   logic                  w_last_g;
   logic [NUM_SLAVES-1:0] w_pop;

   logic [ID_WIDTH-1:0]   w_rid   [NUM_SLAVES];
   logic [DATA_WIDTH-1:0] w_rdata [NUM_SLAVES];
   logic [1:0]            w_rresp [NUM_SLAVES];

   always_comb begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         w_rid[i]   = bus.fifo_RID[i*ID_WIDTH +: ID_WIDTH];
         w_rdata[i] = bus.fifo_RDATA[i*DATA_WIDTH +: DATA_WIDTH];
         w_rresp[i] = bus.fifo_RRESP[i*2 +: 2];
      end
   end

   // Scan last_grant+1 .. last_grant+NUM_SLAVES; the sum is one bit wider
   // so the wrap works for non power-of-two slave counts.
   always_comb begin : rr_scan
      logic [GW:0] cand;
      w_found = 1'b0;
      w_next  = '0;
      cand    = '0;
      for (int unsigned k = 1; k <= NUM_SLAVES; k++) begin
         cand = {1'b0, r_last_grant} + (GW+1)'(k);
         if (cand >= (GW+1)'(NUM_SLAVES)) begin
            cand = cand - (GW+1)'(NUM_SLAVES);
         end
         if (!w_found && !bus.fifo_empty[cand[GW-1:0]]) begin
            w_found = 1'b1;
            w_next  = cand[GW-1:0];
         end
      end
   end

   assign w_in_burst = (r_state == S_BURST);
   assign w_rvalid   = w_in_burst & ~bus.fifo_empty[r_grant];
   assign w_accept   = w_rvalid & bus.RREADY;
   assign w_last_g   = bus.fifo_RLAST[r_grant];

   always_comb begin
      w_pop = '0;
      if (w_accept) begin
         w_pop[r_grant] = 1'b1;
      end
   end

   always_comb begin
      bus.RVALID   = w_rvalid;
      bus.busy     = w_in_burst;
      bus.fifo_pop = w_pop;
      bus.RID      = '0;
      bus.RDATA    = '0;
      bus.RRESP    = '0;
      bus.RLAST    = 1'b0;
      if (w_in_burst) begin
         bus.RID   = w_rid[r_grant];
         bus.RDATA = w_rdata[r_grant];
         bus.RRESP = w_rresp[r_grant];
         bus.RLAST = w_last_g;
      end
   end

   // last_grant resets to the top index so slave 0 wins the first scan.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_grant      <= '0;
         r_last_grant <= GW'(NUM_SLAVES - 1);
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant <= w_next;
                  r_state <= S_BURST;
               end
            end
            S_BURST: begin
               if (w_accept && w_last_g) begin
                  r_state      <= S_IDLE;
                  r_last_grant <= r_grant;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_r_rr_arbiter.sv
// Directed bench for r_rr_arbiter: behavioural r_fifo fronts per slave, hand-computed expected outputs.
module tb_r_rr_arbiter;
   localparam int NS = 4;
   localparam int IW = 4;
   localparam int DW = 32;

   typedef struct packed {
      logic [IW-1:0] rid;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   r_rr_arbiter_if #(.NUM_SLAVES(NS), .ID_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

   r_rr_arbiter #(.NUM_SLAVES(NS), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   beat_t    mem [NS][16];
   bit [3:0] rd_ptr [NS];
   bit [3:0] wr_ptr [NS];
   logic [NS-1:0] hold = '0;

   int tests = 0;
   int fails = 0;

   always @(posedge clk) begin
      for (int i = 0; i < NS; i++) begin
         if (bus.fifo_pop[i] === 1'b1) rd_ptr[i] <= rd_ptr[i] + 4'd1;
      end
   end

   always_comb begin
      beat_t f;
      f = '0;
      bus.fifo_empty = '0;
      bus.fifo_RID   = '0;
      bus.fifo_RDATA = '0;
      bus.fifo_RRESP = '0;
      bus.fifo_RLAST = '0;
      for (int i = 0; i < NS; i++) begin
         f = mem[i][rd_ptr[i]];
         bus.fifo_empty[i]          = (rd_ptr[i] == wr_ptr[i]) || hold[i];
         bus.fifo_RID[i*IW +: IW]   = f.rid;
         bus.fifo_RDATA[i*DW +: DW] = f.data;
         bus.fifo_RRESP[i*2 +: 2]   = f.resp;
         bus.fifo_RLAST[i]          = f.last;
      end
   end

   logic [44:0] w_obs;
   assign w_obs = {bus.RVALID, bus.fifo_pop, bus.RID, bus.RDATA, bus.RRESP, bus.RLAST, bus.busy};

   function automatic logic [44:0] ex(logic v, logic [3:0] pop, logic [3:0] rid,
                                      logic [31:0] d, logic [1:0] resp, logic last, logic busy);
      return {v, pop, rid, d, resp, last, busy};
   endfunction

   task automatic push(int s, logic [3:0] rid, logic [31:0] d, logic [1:0] resp, logic last);
      mem[s][wr_ptr[s]] = '{rid: rid, data: d, resp: resp, last: last};
      wr_ptr[s] = wr_ptr[s] + 4'd1;
   endtask

   task automatic test_reset();
      logic [44:0] e;
      bus.RREADY = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      e = ex(0, 4'b0000, 0, 0, 0, 0, 0);
      tests++;
      if (w_obs !== e) begin
         fails++;
         $display("FAIL reset_held: got %h expected %h", w_obs, e);
      end
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         tests++;
         if (w_obs !== e) begin
            fails++;
            $display("FAIL reset_idle[%0d]: got %h expected %h", c, w_obs, e);
         end
      end
   endtask

   task automatic test_single_burst();
      logic [44:0] e;
      @(negedge clk);
      for (int b = 0; b < 4; b++) push(2, 4'd3, 32'hA0 + b, 2'b00, b == 3);
      #1;
      e = ex(0, 4'b0000, 0, 0, 0, 0, 0);
      tests++;
      if (w_obs !== e) begin
         fails++;
         $display("FAIL single_latency: got %h expected %h", w_obs, e);
      end
      for (int b = 0; b <= 4; b++) begin
         @(negedge clk);
         if (b < 4) e = ex(1, 4'b0100, 4'd3, 32'hA0 + b, 2'b00, b == 3, 1);
         else       e = ex(0, 4'b0000, 0, 0, 0, 0, 0);
         tests++;
         if (w_obs !== e) begin
            fails++;
            $display("FAIL single_beat[%0d]: got %h expected %h", b, w_obs, e);
         end
      end
   endtask

   task automatic test_round_robin();
      int order [5] = '{0, 1, 2, 3, 0};
      logic [44:0] e;
      int s;
      int bn;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         s  = order[k];
         bn = (k == 4) ? 1 : 0;
         for (int b = 0; b < 2; b++)
            push(s, 4'(8 + s), 32'h100 * s + 32'h10 * bn + b, 2'(s), b == 1);
      end
      for (int k = 0; k < 5; k++) begin
         s  = order[k];
         bn = (k == 4) ? 1 : 0;
         for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            if (b < 2) e = ex(1, 4'(1 << s), 4'(8 + s), 32'h100 * s + 32'h10 * bn + b, 2'(s), b == 1, 1);
            else       e = ex(0, 4'b0000, 0, 0, 0, 0, 0);
            tests++;
            if (w_obs !== e) begin
               fails++;
               $display("FAIL rr_grant[%0d].cyc%0d: got %h expected %h", k, b, w_obs, e);
            end
         end
      end
   endtask

   task automatic test_stall_empty();
      logic [44:0] e;
      @(negedge clk);
      for (int b = 0; b < 3; b++) push(1, 4'd5, 32'hB0 + b, 2'b01, b == 2);
      for (int b = 0; b < 2; b++) push(3, 4'd6, 32'hC0 + b, 2'b00, b == 1);
      @(negedge clk);
      e = ex(1, 4'b0010, 4'd5, 32'hB0, 2'b01, 0, 1);
      tests++;
      if (w_obs !== e) begin
         fails++;
         $display("FAIL stall_beat0: got %h expected %h", w_obs, e);
      end
      @(posedge clk);
      #1 hold[1] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         e = ex(0, 4'b0000, 4'd5, 32'hB1, 2'b01, 0, 1);
         tests++;
         if (w_obs !== e) begin
            fails++;
            $display("FAIL stall_empty[%0d]: got %h expected %h", c, w_obs, e);
         end
      end
      hold[1] = 1'b0;
      #1;
      e = ex(1, 4'b0010, 4'd5, 32'hB1, 2'b01, 0, 1);
      tests++;
      if (w_obs !== e) begin
         fails++;
         $display("FAIL stall_resume: got %h expected %h", w_obs, e);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         case (c)
            0:       e = ex(1, 4'b0010, 4'd5, 32'hB2, 2'b01, 1, 1);
            2:       e = ex(1, 4'b1000, 4'd6, 32'hC0, 2'b00, 0, 1);
            3:       e = ex(1, 4'b1000, 4'd6, 32'hC1, 2'b00, 1, 1);
            default: e = ex(0, 4'b0000, 0, 0, 0, 0, 0);
         endcase
         tests++;
         if (w_obs !== e) begin
            fails++;
            $display("FAIL stall_tail[%0d]: got %h expected %h", c, w_obs, e);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [44:0] e;
      @(negedge clk);
      for (int b = 0; b < 3; b++) push(2, 4'd7, 32'hD0 + b, 2'b11, b == 2);
      @(negedge clk);
      e = ex(1, 4'b0100, 4'd7, 32'hD0, 2'b11, 0, 1);
      tests++;
      if (w_obs !== e) begin
         fails++;
         $display("FAIL bp_beat0: got %h expected %h", w_obs, e);
      end
      @(posedge clk);
      #1 bus.RREADY = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         e = ex(1, 4'b0000, 4'd7, 32'hD1, 2'b11, 0, 1);
         tests++;
         if (w_obs !== e) begin
            fails++;
            $display("FAIL bp_hold[%0d]: got %h expected %h", c, w_obs, e);
         end
      end
      bus.RREADY = 1'b1;
      #1;
      e = ex(1, 4'b0100, 4'd7, 32'hD1, 2'b11, 0, 1);
      tests++;
      if (w_obs !== e) begin
         fails++;
         $display("FAIL bp_release: got %h expected %h", w_obs, e);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (c == 0) e = ex(1, 4'b0100, 4'd7, 32'hD2, 2'b11, 1, 1);
         else        e = ex(0, 4'b0000, 0, 0, 0, 0, 0);
         tests++;
         if (w_obs !== e) begin
            fails++;
            $display("FAIL bp_tail[%0d]: got %h expected %h", c, w_obs, e);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [44:0] e;
      @(negedge clk);
      for (int b = 0; b < 4; b++) push(0, 4'd9, 32'hE0 + b, 2'b00, b == 3);
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         e = ex(1, 4'b0001, 4'd9, 32'hE0 + b, 2'b00, 0, 1);
         tests++;
         if (w_obs !== e) begin
            fails++;
            $display("FAIL rmid_beat[%0d]: got %h expected %h", b, w_obs, e);
         end
      end
      #2 rst = 1'b1;
      #1;
      e = ex(0, 4'b0000, 0, 0, 0, 0, 0);
      tests++;
      if (w_obs !== e) begin
         fails++;
         $display("FAIL rmid_async: got %h expected %h", w_obs, e);
      end
      @(negedge clk);
      wr_ptr[0] = rd_ptr[0];
      for (int b = 0; b < 2; b++) push(1, 4'd10, 32'hF8 + b, 2'b00, b == 1);
      for (int b = 0; b < 2; b++) push(0, 4'd9, 32'hF0 + b, 2'b00, b == 1);
      #1;
      tests++;
      if (w_obs !== e) begin
         fails++;
         $display("FAIL rmid_in_reset: got %h expected %h", w_obs, e);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         case (c)
            0:       e = ex(1, 4'b0001, 4'd9,  32'hF0, 2'b00, 0, 1);
            1:       e = ex(1, 4'b0001, 4'd9,  32'hF1, 2'b00, 1, 1);
            3:       e = ex(1, 4'b0010, 4'd10, 32'hF8, 2'b00, 0, 1);
            4:       e = ex(1, 4'b0010, 4'd10, 32'hF9, 2'b00, 1, 1);
            default: e = ex(0, 4'b0000, 0, 0, 0, 0, 0);
         endcase
         tests++;
         if (w_obs !== e) begin
            fails++;
            $display("FAIL rmid_after[%0d]: got %h expected %h", c, w_obs, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_round_robin();
      test_stall_empty();
      test_backpressure();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
